// File: rtl/lag_window_if.sv
// Scratch-memory bus and start/done handshake between the lag-window engine and its host.
// master is the engine side; slave is the memory/sequencer side.
interface lag_window_if;
  logic        start;
  logic        done;
  logic [31:0] memOut;
  logic [11:0] readRequested;
  logic [11:0] writeRequested;
  logic [31:0] memIn;
  logic        memWrite;

  modport master (
    input  start,
    input  memOut,
    output done,
    output readRequested,
    output writeRequested,
    output memIn,
    output memWrite
  );

  modport slave (
    output start,
    output memOut,
    input  done,
    input  readRequested,
    input  writeRequested,
    input  memIn,
    input  memWrite
  );
endinterface

// File: rtl/lag_window.sv
// G.729 lag window: r'[0]=r[0], r'[k]=Mpy_32(r[k], lag[k-1]) for k=1..10,
// streamed word by word over the single-port scratch-memory bus.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RD    | read address SRC_BASE+i presented
// S_LATCH | memory word captured into r
// S_MUL1  | three partial products registered
// S_MUL2  | saturated sum registered as write data
// S_WR    | one-cycle write to DST_BASE+i
// S_DONE  | frame complete, done high until next start
module lag_window #(
  parameter logic [11:0] SRC_BASE = 12'h100,
  parameter logic [11:0] DST_BASE = 12'h180
) (
  input  logic         clk,
  input  logic         reset,
  lag_window_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LATCH, S_MUL1, S_MUL2, S_WR, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [31:1] r_q;
  logic [31:0] p0_q;
  logic [15:0] m1_q, m2_q;

  logic [11:0] rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic        wr_en, done_q;

  logic [3:0]         rom_idx;
  logic [15:0]        coef_h, coef_l;
  logic signed [31:0] hi_x, lo_x, ch_x, cl_x;
  logic signed [31:0] prod_hh, prod_hl, prod_lh;
  logic [31:0]        p0_c, sum1_c, sum2_c;
  logic [15:0]        m1_c, m2_c;

  function automatic logic [15:0] rom_h(input logic [3:0] j);
    case (j)
      4'd0:    rom_h = 16'd32728;
      4'd1:    rom_h = 16'd32619;
      4'd2:    rom_h = 16'd32438;
      4'd3:    rom_h = 16'd32187;
      4'd4:    rom_h = 16'd31867;
      4'd5:    rom_h = 16'd31480;
      4'd6:    rom_h = 16'd31029;
      4'd7:    rom_h = 16'd30517;
      4'd8:    rom_h = 16'd29946;
      4'd9:    rom_h = 16'd29321;
      default: rom_h = 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] rom_l(input logic [3:0] j);
    case (j)
      4'd0:    rom_l = 16'd11904;
      4'd1:    rom_l = 16'd17280;
      4'd2:    rom_l = 16'd30720;
      4'd3:    rom_l = 16'd25856;
      4'd4:    rom_l = 16'd24192;
      4'd5:    rom_l = 16'd28992;
      4'd6:    rom_l = 16'd24384;
      4'd7:    rom_l = 16'd7360;
      4'd8:    rom_l = 16'd19520;
      4'd9:    rom_l = 16'd14784;
      default: rom_l = 16'd0;
    endcase
  endfunction

  // Overflow shows up as disagreement between the two top bits of a 33-bit sum.
  function automatic logic [31:0] sat32(input logic signed [32:0] v);
    if (v[32] != v[31]) sat32 = v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else                sat32 = v[31:0];
  endfunction

  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       sat16 = 16'h7FFF;
    else if (v < -32'sd32768) sat16 = 16'h8000;
    else                      sat16 = v[15:0];
  endfunction

  // Window entries are all below 32768, so they are positive as 16-bit signed.
  always_comb begin
    rom_idx = idx - 4'd1;
    coef_h  = rom_h(rom_idx);
    coef_l  = rom_l(rom_idx);
    hi_x    = {{16{r_q[31]}}, r_q[31:16]};
    lo_x    = {17'd0, r_q[15:1]};
    ch_x    = {16'd0, coef_h};
    cl_x    = {16'd0, coef_l};
    prod_hh = hi_x * ch_x;
    prod_hl = hi_x * cl_x;
    prod_lh = lo_x * ch_x;
    p0_c    = sat32({prod_hh, 1'b0});
    m1_c    = sat16(prod_hl >>> 15);
    m2_c    = sat16(prod_lh >>> 15);
    sum1_c  = sat32($signed({p0_q[31], p0_q}) + $signed({{16{m1_q[15]}}, m1_q, 1'b0}));
    sum2_c  = sat32($signed({sum1_c[31], sum1_c}) + $signed({{16{m2_q[15]}}, m2_q, 1'b0}));
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE:  if (bus.start) begin state_n = S_RD; idx_n = 4'd0; end
      S_RD:    state_n = S_LATCH;
      S_LATCH: state_n = (idx == 4'd0) ? S_WR : S_MUL1;
      S_MUL1:  state_n = S_MUL2;
      S_MUL2:  state_n = S_WR;
      S_WR: begin
        if (idx == 4'd10) state_n = S_DONE;
        else begin
          state_n = S_RD;
          idx_n   = idx + 4'd1;
        end
      end
      S_DONE:  if (bus.start) begin state_n = S_RD; idx_n = 4'd0; end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= 4'd0;
      r_q     <= '0;
      p0_q    <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (state == S_LATCH) r_q <= bus.memOut[31:1];
      if (state == S_MUL1) begin
        p0_q <= p0_c;
        m1_q <= m1_c;
        m2_q <= m2_c;
      end
      if (state_n == S_RD) rd_addr <= SRC_BASE + {8'd0, idx_n};
      // Write strobe, address and data live only for the WR cycle; r[0] bypasses the multiplier.
      wr_en   <= (state_n == S_WR);
      wr_addr <= (state_n == S_WR) ? DST_BASE + {8'd0, idx} : 12'd0;
      if (state_n == S_WR) wr_data <= (state == S_LATCH) ? bus.memOut : sum2_c;
      else                 wr_data <= 32'd0;
      done_q <= (state_n == S_DONE);
    end
  end

  assign bus.readRequested  = rd_addr;
  assign bus.writeRequested = wr_addr;
  assign bus.memIn          = wr_data;
  assign bus.memWrite       = wr_en;
  assign bus.done           = done_q;

endmodule
